// File: rtl/trivium_pkg.sv
// Shared constants, types and helpers for the Trivium keystream generator.
// Internal state bit i (0-based) holds Trivium state bit s(i+1).
package trivium_pkg;

  localparam int STATE_W             = 288;
  localparam int KEY_W               = 80;
  localparam int IV_W                = 80;
  localparam int INIT_ROUNDS_DEFAULT = 1152;

  // Register boundaries: A = s1..s93, B = s94..s177, C = s178..s288
  localparam int R1_LO = 0;
  localparam int R1_HI = 92;
  localparam int R2_LO = 93;
  localparam int R2_HI = 176;
  localparam int R3_LO = 177;
  localparam int R3_HI = 287;

  // t1 = s66^s93, AND s91&s92, feedback s171
  localparam int T1_TAP_A = 65;
  localparam int T1_TAP_B = 92;
  localparam int T1_AND_A = 90;
  localparam int T1_AND_B = 91;
  localparam int T1_FB    = 170;

  // t2 = s162^s177, AND s175&s176, feedback s264
  localparam int T2_TAP_A = 161;
  localparam int T2_TAP_B = 176;
  localparam int T2_AND_A = 174;
  localparam int T2_AND_B = 175;
  localparam int T2_FB    = 263;

  // t3 = s243^s288, AND s286&s287, feedback s69
  localparam int T3_TAP_A = 242;
  localparam int T3_TAP_B = 287;
  localparam int T3_AND_A = 285;
  localparam int T3_AND_B = 286;
  localparam int T3_FB    = 68;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } fsm_e;

  // Key in s1..s80, IV in s94..s173, ones in s286..s288, zeros elsewhere.
  function automatic state_t load_image(input logic [KEY_W-1:0] key,
                                        input logic [IV_W-1:0]  iv);
    state_t s;
    s                 = '0;
    s[R1_LO +: KEY_W] = key;
    s[R2_LO +: IV_W]  = iv;
    s[R3_HI -: 3]     = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_step.sv
// Combinational chain of WORD_W Trivium rounds. Round k consumes the
// state left by round k-1 and its output bit lands in z[k].
module trivium_step
  import trivium_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  state_t              state_in,
  output state_t              state_out,
  output logic [WORD_W-1:0]   z
);

  for (genvar k = 0; k < WORD_W; k++) begin : g_round
    state_t s_in;
    state_t s_out;
    logic   t1;
    logic   t2;
    logic   t3;
    logic   f1;
    logic   f2;
    logic   f3;

    if (k == 0) begin : g_first
      assign s_in = state_in;
    end else begin : g_next
      assign s_in = g_round[k-1].s_out;
    end

    assign t1   = s_in[T1_TAP_A] ^ s_in[T1_TAP_B];
    assign t2   = s_in[T2_TAP_A] ^ s_in[T2_TAP_B];
    assign t3   = s_in[T3_TAP_A] ^ s_in[T3_TAP_B];
    assign z[k] = t1 ^ t2 ^ t3;

    assign f1 = t1 ^ (s_in[T1_AND_A] & s_in[T1_AND_B]) ^ s_in[T1_FB];
    assign f2 = t2 ^ (s_in[T2_AND_A] & s_in[T2_AND_B]) ^ s_in[T2_FB];
    assign f3 = t3 ^ (s_in[T3_AND_A] & s_in[T3_AND_B]) ^ s_in[T3_FB];

    // Each register shifts up by one; A takes f3, B takes f1, C takes f2.
    assign s_out = {s_in[R3_HI-1:R3_LO], f2,
                    s_in[R2_HI-1:R2_LO], f1,
                    s_in[R1_HI-1:R1_LO], f3};
  end

  assign state_out = g_round[WORD_W-1].s_out;

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator: load -> INIT warm-up -> RUN streaming.
// Stream handshake: a word moves when ks_valid && ks_ready at a rising
// edge; while ks_valid=1 and ks_ready=0 the word and state hold. load
// overrides everything and silently drops any pending word.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int INIT_ROUNDS = INIT_ROUNDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [KEY_W-1:0]  key,
  input  logic [IV_W-1:0]   iv,
  output logic              busy,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [WORD_W-1:0] ks_data
);

  localparam int N_STEPS = INIT_ROUNDS / WORD_W;
  localparam int CNT_W   = $clog2(N_STEPS + 1);

  fsm_e              fsm_q, fsm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              ks_valid_q, ks_valid_d;
  logic [WORD_W-1:0] ks_data_q, ks_data_d;

  state_t            step_state;
  logic [WORD_W-1:0] step_z;

  trivium_step #(.WORD_W(WORD_W)) u_step (
    .state_in  (state_q),
    .state_out (step_state),
    .z         (step_z)
  );

  // Next-state logic: load wins, otherwise advance per FSM state.
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    ks_valid_d = ks_valid_q;
    ks_data_d  = ks_data_q;
    if (load) begin
      state_d    = load_image(key, iv);
      cnt_d      = '0;
      fsm_d      = ST_INIT;
      ks_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: ;
        ST_INIT: begin
          state_d = step_state;
          if (cnt_q == CNT_W'(N_STEPS - 1)) begin
            cnt_d = '0;
            fsm_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!ks_valid_q || ks_ready) begin
            state_d    = step_state;
            ks_data_d  = step_z;
            ks_valid_d = 1'b1;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
    busy_d = (fsm_d == ST_INIT);
  end

  // State, counter and registered outputs with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= ST_IDLE;
      cnt_q      <= '0;
      state_q    <= '0;
      busy_q     <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
    end
  end

  assign busy     = busy_q;
  assign ks_valid = ks_valid_q;
  assign ks_data  = ks_data_q;

endmodule

// File: tb/tb_trivium_stream.sv
// Directed bench for trivium_stream: three widths (8, 1, 64) share load,
// key and iv; a bit-serial reference model supplies expected keystream.
module tb_trivium_stream;

  localparam int NB = 10240;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        load;
  logic [79:0] key;
  logic [79:0] iv;

  logic        busy8, valid8, ready8;
  logic [7:0]  data8;
  logic        busy1, valid1, ready1;
  logic [0:0]  data1;
  logic        busy64, valid64, ready64;
  logic [63:0] data64;

  trivium_stream #(.WORD_W(8)) u_dut8 (
    .clk(clk), .rst(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy8), .ks_valid(valid8), .ks_ready(ready8), .ks_data(data8)
  );

  trivium_stream #(.WORD_W(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(valid1), .ks_ready(ready1), .ks_data(data1)
  );

  trivium_stream #(.WORD_W(64)) u_dut64 (
    .clk(clk), .rst(rst_n), .load(load), .key(key), .iv(iv),
    .busy(busy64), .ks_valid(valid64), .ks_ready(ready64), .ks_data(data64)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic mbits [0:NB-1];

  task automatic run_model(input logic [79:0] k, input logic [79:0] v, input int nbits);
    logic s [1:288];
    logic t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i >= 2; i--) s[i] = s[i-1];
      s[1]   = t3;
      s[94]  = t1;
      s[178] = t2;
      if (r >= 1152) mbits[r - 1152] = z;
    end
  endtask

  function automatic logic [7:0] model_byte(input int j);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = mbits[8*j + k];
    return b;
  endfunction

  // ---------------- monitors ----------------
  logic        mon8_en  = 1'b0;
  logic        mon1_en  = 1'b0;
  logic        mon64_en = 1'b0;
  logic        stall_en = 1'b0;
  logic        hold_pending = 1'b0;
  logic [7:0]  held = '0;
  logic [7:0]  got8[$];
  logic        got1[$];
  logic [63:0] got64[$];

  // Record transfers that will occur at the next rising edge, and check
  // that a stalled word stays put.
  always @(negedge clk) begin
    if (mon8_en && valid8 && ready8) got8.push_back(data8);
    if (mon1_en && valid1 && ready1 && got1.size() < 256) got1.push_back(data1[0]);
    if (mon64_en && valid64 && ready64 && got64.size() < 4) got64.push_back(data64);
    if (stall_en) begin
      if (hold_pending) check("stall_hold", {valid8, data8}, {1'b1, held});
      hold_pending <= valid8 && !ready8;
      held         <= data8;
    end else begin
      hold_pending <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic full_run(input logic [79:0] k, input logic [79:0] v, input int nwords,
                          input int nload, input logic [7:0] exp_hold, input string tag);
    logic [7:0] exp_q[$];
    int c;
    run_model(k, v, (nwords + 1) * 8);
    for (int j = 0; j < nwords; j++) exp_q.push_back(model_byte(j));
    got8.delete();
    mon8_en = 1'b0;
    key  = k;
    iv   = v;
    load = 1'b1;
    for (int i = 0; i < nload; i++) step();
    load   = 1'b0;
    ready8 = 1'b1;
    for (int i = 0; i < 144; i++) begin
      check({tag, "_init"}, {busy8, valid8, data8}, {1'b1, 1'b0, exp_hold});
      step();
    end
    check({tag, "_run_entry"}, {busy8, valid8}, 2'b00);
    mon8_en = 1'b1;
    c = 0;
    while (got8.size() < nwords && c < nwords + 20) begin
      step();
      c++;
    end
    mon8_en = 1'b0;
    ready8  = 1'b0;
    check({tag, "_count"}, got8.size(), nwords);
    for (int j = 0; j < nwords && j < got8.size(); j++)
      check({tag, "_word"}, got8[j], exp_q.pop_front());
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]  exp_q[$];
    logic [1:0]  e64;
    logic [63:0] w;
    logic [7:0]  e_pend;
    int          n8;
    int          c;

    rst_n = 1'b1; load = 1'b0; key = '0; iv = '0;
    ready8 = 1'b0; ready1 = 1'b0; ready64 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_w8",  {busy8, valid8, data8}, '0);
    check("rst_w1",  {busy1, valid1, data1}, '0);
    check("rst_w64", {busy64, valid64, data64}, '0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_w8",  {busy8, valid8, data8}, '0);
      check("idle_w1",  {busy1, valid1, data1}, '0);
      check("idle_w64", {busy64, valid64, data64}, '0);
    end

    // Zero key/IV on all three widths, latency and keystream.
    run_model('0, '0, NB);
    ready8 = 1'b1; ready1 = 1'b1; ready64 = 1'b1;
    got8.delete(); got1.delete(); got64.delete();
    mon8_en = 1'b1; mon1_en = 1'b1; mon64_en = 1'b1;
    key = '0; iv = '0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 144; i++) begin
      check("w8_init", {busy8, valid8, data8}, {1'b1, 1'b0, 8'h00});
      check("w1_init", {busy1, valid1}, 2'b10);
      e64 = {(i < 18), (i >= 19)};
      check("w64_init", {busy64, valid64}, e64);
      step();
    end
    check("w8_run_entry", {busy8, valid8}, 2'b00);
    step();
    check("w8_first_valid", {busy8, valid8}, 2'b01);
    repeat (40) step();
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ready8 = 1'($urandom_range(0, 1));
      step();
    end
    stall_en = 1'b0;
    mon8_en  = 1'b0;
    ready8   = 1'b0;
    c = 0;
    while ((got1.size() < 256 || got64.size() < 4) && c < 2000) begin
      step();
      c++;
    end
    mon1_en = 1'b0; mon64_en = 1'b0; ready1 = 1'b0; ready64 = 1'b0;
    check("w1_count", got1.size(), 256);
    check("w64_count", got64.size(), 4);
    check("w8_accepted_min", (got8.size() >= 40), 1'b1);
    n8 = (got8.size() < NB / 8) ? got8.size() : NB / 8;
    for (int j = 0; j < n8; j++) exp_q.push_back(model_byte(j));
    for (int j = 0; j < n8; j++) check("w8_word", got8[j], exp_q.pop_front());
    for (int j = 0; j < got1.size(); j++) check("w1_bit", got1[j], mbits[j]);
    for (int j = 0; j < got64.size(); j++) begin
      for (int k = 0; k < 64; k++) w[k] = mbits[64*j + k];
      check("w64_word", got64[j], w);
    end

    // Reset in the middle of INIT.
    key = 80'h1; iv = '0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (50) step();
    check("pre_rst_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rst_init_async", {busy8, valid8, data8}, '0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_init_idle", {busy8, valid8, data8}, '0);

    // Reload with key=1 at INIT cycle 70 of a zero-key run.
    key = '0; iv = '0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (70) step();
    full_run(80'h1, '0, 32, 1, 8'h00, "midinit");
    e_pend = model_byte(32);
    for (int i = 0; i < 3; i++) begin
      check("pend_hold", {valid8, data8}, {1'b1, e_pend});
      step();
    end

    // Reload in RUN with a word pending; it must be dropped.
    full_run(80'h1, '0, 8, 1, e_pend, "drop");
    e_pend = model_byte(8);

    // Reset in RUN with a pending word.
    check("pre_rst_pending", {valid8, data8}, {1'b1, e_pend});
    rst_n = 1'b0;
    #2;
    check("rst_run_async", {busy8, valid8, data8}, '0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_run_idle", {busy8, valid8, data8}, '0);
    full_run(80'h1, '0, 16, 1, 8'h00, "after_rst");
    e_pend = model_byte(16);

    // load held high for three edges.
    full_run('0, '0, 16, 3, e_pend, "load_x3");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
